// File: rtl/bfs_update_packer_if.sv
// Purpose: bundles the update-FIFO read side, the flush/done sideband and the AXI-Stream beat output of the BFS update packer.
// Latency: none, wires only.
// Backpressure: m_tready from the stream sink; upd_rd_en pops the FWFT update FIFO.
// Modports: master = packer side (drives upd_rd_en, m_t*, upd_count, done); slave = FIFO/sink/control side.
interface bfs_update_packer_if #(
  parameter int UPD_W = 64,
  parameter int PACK  = 8
);
  logic                      upd_valid;
  logic [UPD_W-1:0]          upd_dout;
  logic                      upd_rd_en;
  logic                      flush;
  logic [UPD_W*PACK-1:0]     m_tdata;
  logic [UPD_W*PACK/8-1:0]   m_tkeep;
  logic                      m_tvalid;
  logic                      m_tready;
  logic                      m_tlast;
  logic [31:0]               upd_count;
  logic                      done;

  modport master (
    input  upd_valid, upd_dout, flush, m_tready,
    output upd_rd_en, m_tdata, m_tkeep, m_tvalid, m_tlast, upd_count, done
  );

  modport slave (
    output upd_valid, upd_dout, flush, m_tready,
    input  upd_rd_en, m_tdata, m_tkeep, m_tvalid, m_tlast, upd_count, done
  );
endinterface

// File: rtl/bfs_update_packer.sv
// Purpose: packs PACK vertex updates from a FWFT FIFO into one AXI-Stream beat; flush closes a partial beat with m_tlast.
// Latency: a full beat is valid PACK cycles after its first pop (m_tvalid registered, the cycle after the filling pop).
// Backpressure: while a beat waits for m_tready no pops occur and the beat is held stable.
// Ports: gt_txusrclk clock, peripheral_reset async active-high, bus = bfs_update_packer_if.master.
module bfs_update_packer #(
  parameter int UPD_W = 64,
  parameter int PACK  = 8
) (
  input  logic                  gt_txusrclk,
  input  logic                  peripheral_reset,
  bfs_update_packer_if.master   bus
);

  localparam int SLOT_W = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int LANE_B = UPD_W / 8;
  localparam int KEEP_W = UPD_W * PACK / 8;

  typedef enum logic {FILL, SEND} state_t;

  state_t                 state;
  logic [SLOT_W-1:0]      slot;
  logic                   full;        // slot == PACK, kept apart so slot stays SLOT_W bits
  logic                   flush_pend;
  logic [UPD_W*PACK-1:0]  beat;
  logic [KEEP_W-1:0]      keep_r;
  logic                   tvalid_r;
  logic                   tlast_r;
  logic                   done_r;
  logic [31:0]            cnt;

  logic                   pop;
  logic                   last_lane;
  logic                   flush_seen;
  logic [KEEP_W-1:0]      part_keep;

  // Reset term keeps the pop strobe low while reset is held, even with the FIFO non-empty.
  assign pop        = bus.upd_valid && (state == FILL) && !full && !peripheral_reset;
  assign last_lane  = (slot == SLOT_W'(PACK - 1));
  assign flush_seen = flush_pend | bus.flush;

  // Byte enables for lanes 0..slot-1 of a flushed partial beat.
  always_comb begin
    part_keep = '0;
    for (int k = 0; k < PACK; k++) begin
      if (k < int'(slot)) part_keep[k*LANE_B +: LANE_B] = '1;
    end
  end

  always_ff @(posedge gt_txusrclk or posedge peripheral_reset) begin
    if (peripheral_reset) begin
      state      <= FILL;
      slot       <= '0;
      full       <= 1'b0;
      flush_pend <= 1'b0;
      beat       <= '0;
      keep_r     <= '0;
      tvalid_r   <= 1'b0;
      tlast_r    <= 1'b0;
      done_r     <= 1'b0;
      cnt        <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        FILL: begin
          if (pop) begin
            beat[slot*UPD_W +: UPD_W] <= bus.upd_dout;
            cnt                       <= cnt + 32'd1;
            flush_pend                <= flush_seen;
            if (last_lane) begin
              // The FWFT FIFO gives no lookahead past the head, so a flush already
              // seen when the beat fills marks it as the iteration's last beat
              // instead of emitting an empty trailing beat.
              full     <= 1'b1;
              state    <= SEND;
              tvalid_r <= 1'b1;
              keep_r   <= '1;
              tlast_r  <= flush_seen;
            end else begin
              slot <= slot + 1'b1;
            end
          end else if (flush_pend && !bus.upd_valid) begin
            // FIFO drained after flush: close the partial beat, or finish directly if empty.
            // A flush pulse landing now is absorbed into the pending one.
            if (slot != '0) begin
              state    <= SEND;
              tvalid_r <= 1'b1;
              keep_r   <= part_keep;
              tlast_r  <= 1'b1;
            end else begin
              flush_pend <= 1'b0;
              done_r     <= 1'b1;
            end
          end else begin
            flush_pend <= flush_seen;
          end
        end
        SEND: begin
          if (bus.m_tready) begin
            state    <= FILL;
            slot     <= '0;
            full     <= 1'b0;
            beat     <= '0;
            keep_r   <= '0;
            tvalid_r <= 1'b0;
            tlast_r  <= 1'b0;
            if (tlast_r) begin
              flush_pend <= 1'b0;
              done_r     <= 1'b1;
            end else begin
              flush_pend <= flush_seen;
            end
          end else begin
            flush_pend <= flush_seen;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  assign bus.upd_rd_en = pop;
  assign bus.m_tdata   = beat;
  assign bus.m_tkeep   = keep_r;
  assign bus.m_tvalid  = tvalid_r;
  assign bus.m_tlast   = tlast_r;
  assign bus.upd_count = cnt;
  assign bus.done      = done_r;

endmodule

// File: tb/tb_bfs_update_packer.sv
// Purpose: directed self-checking bench for bfs_update_packer with a small FWFT FIFO model.
// Latency: checks PACK-cycle fill latency, stall holding, flush close and reset behaviour.
// Backpressure: m_tready driven per step; FIFO pops follow upd_rd_en.
module tb_bfs_update_packer;

  localparam int UPD_W = 64;
  localparam int PACK  = 8;
  localparam int DW    = UPD_W * PACK;

  logic gt_txusrclk = 1'b0;
  logic rst = 1'b1;
  always #5 gt_txusrclk = ~gt_txusrclk;

  bfs_update_packer_if #(.UPD_W(UPD_W), .PACK(PACK)) bus ();

  bfs_update_packer #(.UPD_W(UPD_W), .PACK(PACK)) dut (
    .gt_txusrclk      (gt_txusrclk),
    .peripheral_reset (rst),
    .bus              (bus)
  );

  // FWFT FIFO model
  logic [63:0] fmem [0:63];
  int   wr_ptr = 0;
  int   rd_ptr = 0;
  logic fifo_clear = 1'b0;

  assign bus.upd_valid = (wr_ptr != rd_ptr);
  assign bus.upd_dout  = fmem[rd_ptr[5:0]];

  always @(posedge gt_txusrclk) begin
    if (fifo_clear) rd_ptr <= wr_ptr;
    else if (bus.upd_rd_en) rd_ptr <= rd_ptr + 1;
  end

  int done_cnt = 0;
  always @(posedge gt_txusrclk) if (bus.done === 1'b1) done_cnt <= done_cnt + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] id, input logic [31:0] lvl);
    fmem[wr_ptr[5:0]] = {id, lvl};
    wr_ptr++;
  endtask

  task automatic push_n(input int base, input int n, input logic [31:0] lvl);
    for (int i = 0; i < n; i++) push(32'(base + i), lvl);
  endtask

  function automatic logic [DW-1:0] make_beat(input int base, input logic [31:0] lvl, input int n);
    logic [DW-1:0] b;
    b = '0;
    for (int k = 0; k < n; k++) b[k*64 +: 64] = {32'(base + k), lvl};
    return b;
  endfunction

  // Called at a falling edge; returns the number of falling edges waited.
  task automatic wait_tvalid(input int budget, output int cycles);
    cycles = 0;
    while (bus.m_tvalid !== 1'b1 && cycles < budget) begin
      @(negedge gt_txusrclk);
      cycles++;
    end
  endtask

  localparam logic [63:0] KEEP_ALL = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    int c;
    int d0;

    bus.flush    = 1'b0;
    bus.m_tready = 1'b0;

    // Reset state
    repeat (2) @(negedge gt_txusrclk);
    chk("rst_tvalid", DW'(bus.m_tvalid), '0);
    chk("rst_tdata",  bus.m_tdata, '0);
    chk("rst_tkeep",  DW'(bus.m_tkeep), '0);
    chk("rst_tlast",  DW'(bus.m_tlast), '0);
    chk("rst_count",  DW'(bus.upd_count), '0);
    chk("rst_done",   DW'(bus.done), '0);
    chk("rst_rd_en",  DW'(bus.upd_rd_en), '0);
    rst = 1'b0;
    @(negedge gt_txusrclk);

    // 8 full updates, ready high
    bus.m_tready = 1'b1;
    push_n(1, 8, 32'd3);
    wait_tvalid(20, c);
    chk("t1_latency", DW'(c), DW'(8));
    chk("t1_tvalid", DW'(bus.m_tvalid), DW'(1));
    chk("t1_tdata",  bus.m_tdata, make_beat(1, 32'd3, 8));
    chk("t1_tkeep",  DW'(bus.m_tkeep), DW'(KEEP_ALL));
    chk("t1_tlast",  DW'(bus.m_tlast), '0);
    chk("t1_count",  DW'(bus.upd_count), DW'(8));
    @(negedge gt_txusrclk);
    chk("t1_tvalid_after", DW'(bus.m_tvalid), '0);
    chk("t1_no_done", DW'(done_cnt), '0);

    // 3 updates then flush -> partial last beat
    push_n(11, 3, 32'd5);
    bus.flush = 1'b1;
    @(negedge gt_txusrclk);
    bus.flush = 1'b0;
    wait_tvalid(20, c);
    chk("t2_tvalid", DW'(bus.m_tvalid), DW'(1));
    chk("t2_tdata",  bus.m_tdata, make_beat(11, 32'd5, 3));
    chk("t2_tkeep",  DW'(bus.m_tkeep), DW'(64'h0000_0000_00FF_FFFF));
    chk("t2_tlast",  DW'(bus.m_tlast), DW'(1));
    chk("t2_done_early", DW'(bus.done), '0);
    chk("t2_count",  DW'(bus.upd_count), DW'(11));
    @(negedge gt_txusrclk);
    chk("t2_done", DW'(bus.done), DW'(1));
    chk("t2_tvalid_after", DW'(bus.m_tvalid), '0);
    @(negedge gt_txusrclk);
    chk("t2_done_pulse", DW'(bus.done), '0);

    // flush with no updates -> done only
    d0 = done_cnt;
    bus.flush = 1'b1;
    @(negedge gt_txusrclk);
    bus.flush = 1'b0;
    c = 1;
    while (bus.done !== 1'b1 && c < 6) begin
      @(negedge gt_txusrclk);
      c++;
    end
    chk("t3_done_delay", DW'(c), DW'(2));
    chk("t3_no_beat", DW'(bus.m_tvalid), '0);
    repeat (3) @(negedge gt_txusrclk);
    chk("t3_done_cnt", DW'(done_cnt), DW'(d0 + 1));
    chk("t3_no_beat_later", DW'(bus.m_tvalid), '0);

    // 16 updates with a 5-cycle stall on the first beat
    d0 = done_cnt;
    bus.m_tready = 1'b0;
    push_n(21, 16, 32'd7);
    wait_tvalid(20, c);
    chk("t4_latency", DW'(c), DW'(8));
    for (int i = 0; i < 5; i++) begin
      chk("t4_stall_tvalid", DW'(bus.m_tvalid), DW'(1));
      chk("t4_stall_rd_en", DW'(bus.upd_rd_en), '0);
      chk("t4_stall_tdata", bus.m_tdata, make_beat(21, 32'd7, 8));
      chk("t4_stall_tkeep", DW'(bus.m_tkeep), DW'(KEEP_ALL));
      @(negedge gt_txusrclk);
    end
    bus.m_tready = 1'b1;
    @(negedge gt_txusrclk);
    wait_tvalid(20, c);
    chk("t4_b2_tvalid", DW'(bus.m_tvalid), DW'(1));
    chk("t4_b2_tdata", bus.m_tdata, make_beat(29, 32'd7, 8));
    chk("t4_b2_tlast", DW'(bus.m_tlast), '0);
    @(negedge gt_txusrclk);
    chk("t4_count", DW'(bus.upd_count), DW'(27));
    chk("t4_no_done", DW'(done_cnt), DW'(d0));

    // 8 updates with flush mid-stream -> one last beat, one done
    d0 = done_cnt;
    push_n(41, 8, 32'd9);
    repeat (3) @(negedge gt_txusrclk);
    bus.flush = 1'b1;
    @(negedge gt_txusrclk);
    bus.flush = 1'b0;
    wait_tvalid(20, c);
    chk("t5_tvalid", DW'(bus.m_tvalid), DW'(1));
    chk("t5_tdata", bus.m_tdata, make_beat(41, 32'd9, 8));
    chk("t5_tkeep", DW'(bus.m_tkeep), DW'(KEEP_ALL));
    chk("t5_tlast", DW'(bus.m_tlast), DW'(1));
    @(negedge gt_txusrclk);
    repeat (4) @(negedge gt_txusrclk);
    chk("t5_done_cnt", DW'(done_cnt), DW'(d0 + 1));
    chk("t5_no_beat", DW'(bus.m_tvalid), '0);
    chk("t5_count", DW'(bus.upd_count), DW'(35));

    // reset after 5 pops
    push_n(51, 8, 32'd4);
    repeat (5) @(negedge gt_txusrclk);
    rst = 1'b1;
    #1;
    chk("t6_rst_tvalid", DW'(bus.m_tvalid), '0);
    chk("t6_rst_tdata",  bus.m_tdata, '0);
    chk("t6_rst_tkeep",  DW'(bus.m_tkeep), '0);
    chk("t6_rst_count",  DW'(bus.upd_count), '0);
    chk("t6_rst_rd_en",  DW'(bus.upd_rd_en), '0);
    fifo_clear = 1'b1;
    repeat (2) @(negedge gt_txusrclk);
    fifo_clear = 1'b0;
    rst = 1'b0;
    repeat (4) @(negedge gt_txusrclk);
    chk("t6_idle_tvalid", DW'(bus.m_tvalid), '0);
    push_n(61, 8, 32'd2);
    wait_tvalid(20, c);
    chk("t6_latency", DW'(c), DW'(8));
    chk("t6_tdata", bus.m_tdata, make_beat(61, 32'd2, 8));
    chk("t6_tlast", DW'(bus.m_tlast), '0);
    chk("t6_count", DW'(bus.upd_count), DW'(8));
    @(negedge gt_txusrclk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
